queue_stack_param: RTL and testbench
====================================

Name: queue_stack_param

Overview:
- Parametrised buffer storing WIDTH-bit words, DEPTH entries deep.
- Runtime-selectable FIFO (queue) or LIFO (stack) order.
- Registered read data, occupancy count, full/empty flags, sticky overflow/underflow error flags, synchronous flush.
- Successor to the fixed 2-bit, 256-entry queue; drop-in for the datapath's token buffers.

Parameters:
- WIDTH, 2, data word width in bits (>=1)
- DEPTH, 256, number of entries (>=2, need not be a power of two)
- CW, $clog2(DEPTH)+1, count width (derived, localparam)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  order request: 0 = FIFO, 1 = LIFO
- flush  input  1  synchronous clear of contents and error flags
- enqueue  input  1  write request
- dequeue  input  1  read request
- data_in  input  WIDTH  write data
- data_out  output  WIDTH  registered read data
- out_valid  output  1  one-cycle pulse: data_out updated this cycle
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- count  output  CW  current occupancy, 0..DEPTH
- overflow  output  1  sticky: enqueue rejected while full
- underflow  output  1  sticky: dequeue rejected while empty
- mode_active  output  1  order currently in force

Behaviour:
- Reset (rst=1, async):
  - head, tail, count = 0; data_out = 0; out_valid = 0; overflow = underflow = 0.
  - mode_active = 0.
  - Memory contents not reset.
- empty and full are combinational from the count register.
- Mode latch: mode_active <= mode on any clock edge where count==0 (after the edge's own updates) or flush=1. A mode change while non-empty is deferred until the buffer drains.
- FIFO (mode_active=0):
  - Write at tail; read from head.
  - Each pointer wraps DEPTH-1 -> 0 explicitly; no reliance on power-of-two overflow.
- LIFO (mode_active=1):
  - count acts as stack pointer; push writes mem[count]; pop reads mem[count-1].
  - head and tail unused; both held at 0.
- Accepted dequeue (dequeue=1, count>0):
  - data_out <= selected entry on the same edge, with out_valid=1 that cycle (one-cycle latency from request).
  - Otherwise out_valid=0 and data_out holds its last value.
- Accepted enqueue: stores data_in on the edge.
- Simultaneous enqueue+dequeue:
  - count==0: enqueue only; dequeue rejected (underflow set); no bypass.
  - FIFO, count>0 (including full): both accepted; count unchanged; head and tail both advance.
  - LIFO, count>0 (including full): data_out <= mem[count-1], then mem[count-1] <= data_in (top replaced); count unchanged.
- Rejections:
  - Enqueue alone while full: dropped; overflow <= 1; memory and count unchanged.
  - Dequeue while empty: underflow <= 1; data_out holds; out_valid=0.
  - Both error flags stay set until flush or rst.
- flush=1:
  - Next edge: head = tail = count = 0; overflow = underflow = 0; out_valid = 0; data_out holds.
  - enqueue and dequeue ignored that cycle.
  - flush has priority over all requests.
- count is always updated by +1, -1 or 0 from one decision per edge; the register is never written twice in a cycle.

Test Plan:
- FIFO basic, WIDTH=2 DEPTH=4: enqueue 1,2,3 then dequeue x3 -> data_out 1,2,3 on consecutive cycles, out_valid high each; count 3->0; empty=1 at end.
- LIFO basic, mode=1 from reset: push 1,2,3, pop x3 -> data_out 3,2,1; empty=1 at end.
- Full/overflow, DEPTH=4: enqueue 0,1,2,3 -> full=1, count=4. Enqueue 2 -> overflow=1, count stays 4. Dequeue x4 -> 0,1,2,3 (dropped 2 never appears).
- Wrap plus simultaneous ops, FIFO DEPTH=4: 6 cycles of enqueue+dequeue starting at count=1 -> count stays 1; output stream equals input stream delayed by one entry across pointer wrap.
- LIFO simultaneous at full, DEPTH=4: stack 0,1,2,3; push 1 with pop -> data_out=3, count=4; next pop -> 1.
- Underflow, flush, mode, reset:
  - Dequeue on empty -> underflow=1, out_valid=0.
  - Set mode=1 with count=2 -> mode_active stays 0 until drained.
  - flush -> count=0, both error flags 0.
  - Assert rst mid-burst -> all outputs to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/queue_stack_param_if.sv
// Request/response bundle for queue_stack_param: order select, flush, enqueue/dequeue
// requests and the registered read data with occupancy and error status.
interface queue_stack_param_if #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             mode;
  logic             flush;
  logic             enqueue;
  logic             dequeue;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             mode_active;

  modport master (
    output mode, flush, enqueue, dequeue, data_in,
    input  data_out, out_valid, empty, full, count, overflow, underflow, mode_active
  );

  modport slave (
    input  mode, flush, enqueue, dequeue, data_in,
    output data_out, out_valid, empty, full, count, overflow, underflow, mode_active
  );
endinterface

// File: rtl/queue_stack_param.sv
// WIDTH x DEPTH buffer with runtime FIFO/LIFO order, registered read data,
// sticky overflow/underflow flags and synchronous flush.
module queue_stack_param #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256
) (
  input logic                clk,
  input logic                rst,
  queue_stack_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail, rd_addr, wr_addr, top_idx;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q, ovf_q, unf_q, mode_q;
  logic             is_empty, is_full, deq_ok, enq_ok, ovf_set, unf_set;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  // Modulo-2^PW subtraction is exact here because the true index is always < DEPTH.
  assign top_idx  = count_q[PW-1:0] - PW'(1);

  always_comb begin
    deq_ok  = bus.dequeue && !bus.flush && !is_empty;
    enq_ok  = bus.enqueue && !bus.flush && (!is_full || deq_ok);
    ovf_set = bus.enqueue && !bus.flush && is_full && !deq_ok;
    unf_set = bus.dequeue && !bus.flush && is_empty;

    count_d = count_q;
    if (bus.flush)
      count_d = '0;
    else if (enq_ok && !deq_ok)
      count_d = count_q + CW'(1);
    else if (deq_ok && !enq_ok)
      count_d = count_q - CW'(1);

    rd_addr = mode_q ? top_idx : head;
    wr_addr = tail;
    // A stack push paired with a pop overwrites the top entry in place.
    if (mode_q)
      wr_addr = deq_ok ? top_idx : count_q[PW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= deq_ok;
      if (deq_ok)
        dout_q <= mem[rd_addr];

      if (bus.flush) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (ovf_set) ovf_q <= 1'b1;
        if (unf_set) unf_q <= 1'b1;
      end

      if (bus.flush || mode_q) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (deq_ok) head <= wrap_inc(head);
        if (enq_ok) tail <= wrap_inc(tail);
      end

      // Order changes only take effect once the buffer is (or becomes) empty.
      if (bus.flush || count_d == '0)
        mode_q <= bus.mode;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok)
      mem[wr_addr] <= bus.data_in;
  end

  assign bus.data_out    = dout_q;
  assign bus.out_valid   = valid_q;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.mode_active = mode_q;
endmodule

// File: tb/tb_queue_stack_param.sv
// Bench for queue_stack_param (WIDTH=2, DEPTH=4): vector table, directed corner
// sequences and random traffic against a queue-based order model.
module tb_queue_stack_param;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  queue_stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  queue_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf, m_unf, m_mode;

  typedef struct {
    logic       mode, flush, enq, deq;
    logic [1:0] din;
    logic [1:0] e_dout;
    logic       e_valid;
    int         e_count;
    logic       e_ovf, e_unf;
  } vec_t;

  vec_t vecs[18];

  task automatic model_reset();
    model_q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_mode  = 1'b0;
  endtask

  task automatic model_step(input logic mode, input logic flush, input logic enq,
                            input logic deq, input logic [WIDTH-1:0] din);
    int sz;
    bit d_ok, e_ok;
    if (flush) begin
      model_q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_valid = 1'b0;
      m_mode  = mode;
    end else begin
      sz   = model_q.size();
      d_ok = deq && sz > 0;
      e_ok = enq && (sz < DEPTH || d_ok);
      if (enq && sz == DEPTH && !deq) m_ovf = 1'b1;
      if (deq && sz == 0) m_unf = 1'b1;
      m_valid = d_ok;
      if (d_ok) m_dout = m_mode ? model_q.pop_back() : model_q.pop_front();
      if (e_ok) model_q.push_back(din);
      if (model_q.size() == 0) m_mode = mode;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic mode, input logic flush, input logic enq,
                                input logic deq, input logic [WIDTH-1:0] din);
    @(negedge clk);
    bus.mode    = mode;
    bus.flush   = flush;
    bus.enqueue = enq;
    bus.dequeue = deq;
    bus.data_in = din;
    @(posedge clk);
    #1;
    model_step(mode, flush, enq, deq, din);
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " count"}, 32'(bus.count), 32'(model_q.size()));
    check_output({tag, " empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    check_output({tag, " full"}, 32'(bus.full), 32'(model_q.size() == DEPTH));
    check_output({tag, " data_out"}, 32'(bus.data_out), 32'(m_dout));
    check_output({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check_output({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check_output({tag, " underflow"}, 32'(bus.underflow), 32'(m_unf));
    check_output({tag, " mode_active"}, 32'(bus.mode_active), 32'(m_mode));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " count"}, 32'(bus.count), 0);
    check_output({tag, " empty"}, 32'(bus.empty), 1);
    check_output({tag, " full"}, 32'(bus.full), 0);
    check_output({tag, " data_out"}, 32'(bus.data_out), 0);
    check_output({tag, " out_valid"}, 32'(bus.out_valid), 0);
    check_output({tag, " overflow"}, 32'(bus.overflow), 0);
    check_output({tag, " underflow"}, 32'(bus.underflow), 0);
    check_output({tag, " mode_active"}, 32'(bus.mode_active), 0);
  endtask

  initial begin
    // mode, flush, enq, deq, din | dout, valid, count, ovf, unf
    vecs[0]  = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 1, 0, 2, 0, 0, 2, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 3, 0, 0, 3, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 1, 1, 2, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 2, 1, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 3, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 3, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 1, 3, 0, 2, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 2, 3, 0, 3, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 3, 3, 0, 4, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 2, 3, 0, 4, 1, 0};
    vecs[12] = '{0, 0, 0, 1, 0, 0, 1, 3, 1, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 1, 1, 2, 1, 0};
    vecs[14] = '{0, 0, 0, 1, 0, 2, 1, 1, 1, 0};
    vecs[15] = '{0, 0, 0, 1, 0, 3, 1, 0, 1, 0};
    vecs[16] = '{0, 0, 0, 1, 0, 3, 0, 0, 1, 1};
    vecs[17] = '{0, 1, 0, 0, 0, 3, 0, 0, 0, 0};

    rst         = 1'b1;
    bus.mode    = 1'b0;
    bus.flush   = 1'b0;
    bus.enqueue = 1'b0;
    bus.dequeue = 1'b0;
    bus.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].mode, vecs[i].flush, vecs[i].enq, vecs[i].deq, vecs[i].din);
      check_output($sformatf("vec%0d data_out", i), 32'(bus.data_out), 32'(vecs[i].e_dout));
      check_output($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
      check_output($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].e_count));
      check_output($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].e_count == 0));
      check_output($sformatf("vec%0d full", i), 32'(bus.full), 32'(vecs[i].e_count == DEPTH));
      check_output($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
      check_output($sformatf("vec%0d underflow", i), 32'(bus.underflow), 32'(vecs[i].e_unf));
    end

    // FIFO wrap with simultaneous enqueue+dequeue at count=1
    apply_stimulus(0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 6; i++) begin
      logic [1:0] din_v, exp_v;
      din_v = 2'(i);
      exp_v = 2'(i - 1);
      apply_stimulus(0, 0, 1, 1, din_v);
      check_output($sformatf("wrap%0d data_out", i), 32'(bus.data_out), 32'(exp_v));
      check_output($sformatf("wrap%0d out_valid", i), 32'(bus.out_valid), 1);
      check_output($sformatf("wrap%0d count", i), 32'(bus.count), 1);
    end
    apply_stimulus(0, 0, 0, 1, 2'd0);
    check_output("wrap drain data_out", 32'(bus.data_out), 2);
    check_model("wrap end");

    // LIFO basic
    apply_stimulus(1, 0, 0, 0, 2'd0);
    check_output("lifo mode_active", 32'(bus.mode_active), 1);
    apply_stimulus(1, 0, 1, 0, 2'd1);
    apply_stimulus(1, 0, 1, 0, 2'd2);
    apply_stimulus(1, 0, 1, 0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 1, 2'd0);
      check_output($sformatf("lifo pop%0d data_out", i), 32'(bus.data_out), 32'(3 - i));
      check_output($sformatf("lifo pop%0d out_valid", i), 32'(bus.out_valid), 1);
    end
    check_output("lifo empty", 32'(bus.empty), 1);

    // LIFO push+pop while full replaces the top entry
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 1, 0, 2'(i));
    check_output("lifo full", 32'(bus.full), 1);
    apply_stimulus(1, 0, 1, 1, 2'd1);
    check_output("lifo swap data_out", 32'(bus.data_out), 3);
    check_output("lifo swap count", 32'(bus.count), 4);
    check_output("lifo swap overflow", 32'(bus.overflow), 0);
    apply_stimulus(1, 0, 0, 1, 2'd0);
    check_output("lifo after swap data_out", 32'(bus.data_out), 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0, 0, 1, 2'd0);
      check_output($sformatf("lifo drain%0d data_out", i), 32'(bus.data_out), 32'(2 - i));
    end
    check_model("lifo end");

    // flush latches mode, underflow, deferred mode change
    apply_stimulus(0, 1, 0, 0, 2'd0);
    check_output("flush mode_active", 32'(bus.mode_active), 0);
    apply_stimulus(0, 0, 0, 1, 2'd0);
    check_output("underflow flag", 32'(bus.underflow), 1);
    check_output("underflow out_valid", 32'(bus.out_valid), 0);
    check_output("underflow data_out", 32'(bus.data_out), 0);
    apply_stimulus(0, 0, 1, 0, 2'd1);
    apply_stimulus(0, 0, 1, 0, 2'd2);
    apply_stimulus(1, 0, 0, 0, 2'd0);
    apply_stimulus(1, 0, 0, 0, 2'd0);
    check_output("deferred mode_active", 32'(bus.mode_active), 0);
    check_output("deferred count", 32'(bus.count), 2);
    apply_stimulus(1, 0, 0, 1, 2'd0);
    check_output("deferred pop1 data_out", 32'(bus.data_out), 1);
    check_output("deferred pop1 mode_active", 32'(bus.mode_active), 0);
    apply_stimulus(1, 0, 0, 1, 2'd0);
    check_output("deferred pop2 data_out", 32'(bus.data_out), 2);
    check_output("drained mode_active", 32'(bus.mode_active), 1);
    apply_stimulus(1, 0, 1, 0, 2'd3);
    apply_stimulus(0, 1, 1, 1, 2'd2);
    check_output("flush count", 32'(bus.count), 0);
    check_output("flush underflow", 32'(bus.underflow), 0);
    check_output("flush out_valid", 32'(bus.out_valid), 0);
    check_output("flush data_out", 32'(bus.data_out), 2);
    check_model("flush end");

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r_mode, r_flush, r_enq, r_deq;
      logic [1:0] r_din;
      r_mode  = ($urandom_range(0, 7) == 0) ? ~bus.mode : bus.mode;
      r_flush = ($urandom_range(0, 24) == 0);
      r_enq   = ($urandom_range(0, 99) < 55);
      r_deq   = ($urandom_range(0, 99) < 45);
      r_din   = 2'($urandom);
      apply_stimulus(r_mode, r_flush, r_enq, r_deq, r_din);
      check_model($sformatf("rand%0d", i));
    end

    // asynchronous reset in the middle of a LIFO burst
    apply_stimulus(1, 1, 0, 0, 2'd0);
    apply_stimulus(1, 0, 1, 0, 2'd1);
    apply_stimulus(1, 0, 1, 0, 2'd2);
    apply_stimulus(1, 0, 1, 0, 2'd3);
    apply_stimulus(1, 0, 1, 0, 2'd3);
    apply_stimulus(1, 0, 1, 0, 2'd2);
    apply_stimulus(1, 0, 0, 1, 2'd0);
    check_model("pre-reset");
    #2;
    rst         = 1'b1;
    bus.enqueue = 1'b0;
    bus.dequeue = 1'b0;
    bus.mode    = 1'b0;
    #1;
    check_reset_values("async reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 0, 1, 0, 2'd2);
    check_model("post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
